// File: rtl/select_eps.sv
// select_eps: averages NUM_AVG buffered angles picked at timing-peak indices and
// emits their rounded mean as the fractional CFO estimate eps.
module select_eps #(
  parameter int ANG_W     = 13,
  parameter int NUM_AVG   = 4,
  parameter int STALE_MAX = 192,
  parameter int WAIT_MAX  = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   buf_valid,
  input  logic [256*ANG_W-1:0]   angle_buf,
  input  logic [7:0]             write_ptr,
  input  logic                   peak_valid,
  input  logic [7:0]             peak_idx,
  output logic                   eps_valid,
  output logic [ANG_W-1:0]       eps,
  output logic                   eps_err,
  output logic                   peak_drop,
  output logic                   busy
);

  localparam int L     = $clog2(NUM_AVG);
  localparam int ACC_W = ANG_W + L;
  localparam int CNT_W = $clog2(NUM_AVG) + 1;
  localparam int WC_W  = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_AVG - 1);
  localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(WAIT_MAX - 1);
  localparam logic [7:0]       STALE_LIM = 8'(STALE_MAX);
  localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(NUM_AVG / 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_READ = 3'd2,
    S_ACC  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  // Distance from an index to the write pointer; modulo-256 by 8-bit wrap.
  function automatic logic [7:0] dist_f(input logic [7:0] wp, input logic [7:0] idx);
    return wp - idx;
  endfunction

  state_t                    state_r, state_nx_s;
  logic [7:0]                idx_r, idx_nx_s;
  logic signed [ANG_W-1:0]   sample_r;
  logic signed [ACC_W-1:0]   acc_r, acc_nx_s;
  logic [CNT_W-1:0]          cnt_r, cnt_nx_s;
  logic [WC_W-1:0]           wait_r, wait_nx_s;
  logic [ANG_W-1:0]          eps_r, eps_nx_s;
  logic                      eps_valid_r, eps_valid_nx_s;
  logic                      eps_err_r, eps_err_nx_s;
  logic                      peak_drop_r, peak_drop_nx_s;
  logic                      busy_r;
  logic [15:0]               buf_wr_cnt_r;

  logic [7:0]                peak_dist_s;
  logic [7:0]                idx_dist_s;
  logic signed [ACC_W-1:0]   sum_s;
  logic signed [ACC_W:0]     rnd_s;
  logic signed [ACC_W:0]     shifted_s;

  assign peak_dist_s = dist_f(write_ptr, peak_idx);
  assign idx_dist_s  = dist_f(write_ptr, idx_r);

  // Running sum including the sample being accumulated, and its rounded mean.
  always_comb begin
    sum_s     = acc_r + ACC_W'(sample_r);
    rnd_s     = (ACC_W + 1)'(sum_s) + HALF;
    shifted_s = rnd_s >>> L;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx_s     = state_r;
    idx_nx_s       = idx_r;
    acc_nx_s       = acc_r;
    cnt_nx_s       = cnt_r;
    wait_nx_s      = wait_r;
    eps_nx_s       = eps_r;
    eps_valid_nx_s = 1'b0;
    eps_err_nx_s   = 1'b0;
    if (peak_valid && (state_r != S_IDLE)) begin
      peak_drop_nx_s = 1'b1;
    end else begin
      peak_drop_nx_s = 1'b0;
    end
    case (state_r)
      S_IDLE: begin
        if (peak_valid) begin
          idx_nx_s = peak_idx;
          if (peak_dist_s == 8'd0) begin
            state_nx_s = S_WAIT;
            wait_nx_s  = '0;
          end else if (peak_dist_s <= STALE_LIM) begin
            state_nx_s = S_READ;
          end else begin
            eps_err_nx_s = 1'b1;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_WAIT: begin
        // The buffer entry is written on the same edge the pointer moves past it.
        if (idx_dist_s != 8'd0) begin
          state_nx_s = S_READ;
        end else if (wait_r == WAIT_LAST) begin
          state_nx_s   = S_IDLE;
          eps_err_nx_s = 1'b1;
        end else begin
          wait_nx_s = wait_r + WC_W'(1);
        end
      end
      S_READ: begin
        state_nx_s = S_ACC;
      end
      S_ACC: begin
        acc_nx_s = sum_s;
        cnt_nx_s = cnt_r + CNT_W'(1);
        // eps is registered on entry to OUT so eps_valid is high during OUT.
        if (cnt_r == CNT_LAST) begin
          state_nx_s     = S_OUT;
          eps_nx_s       = shifted_s[ANG_W-1:0];
          eps_valid_nx_s = 1'b1;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_OUT: begin
        acc_nx_s   = '0;
        cnt_nx_s   = '0;
        state_nx_s = S_IDLE;
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      idx_r       <= '0;
      sample_r    <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      wait_r      <= '0;
      eps_r       <= '0;
      eps_valid_r <= 1'b0;
      eps_err_r   <= 1'b0;
      peak_drop_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      idx_r       <= idx_nx_s;
      acc_r       <= acc_nx_s;
      cnt_r       <= cnt_nx_s;
      wait_r      <= wait_nx_s;
      eps_r       <= eps_nx_s;
      eps_valid_r <= eps_valid_nx_s;
      eps_err_r   <= eps_err_nx_s;
      peak_drop_r <= peak_drop_nx_s;
      busy_r      <= (state_nx_s != S_IDLE);
      if (state_r == S_READ) begin
        sample_r <= angle_buf[int'(idx_r)*ANG_W +: ANG_W];
      end
    end
  end

  // Debug tally of buffer writes; not part of control.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_wr_cnt_r <= '0;
    end else if (buf_valid) begin
      buf_wr_cnt_r <= buf_wr_cnt_r + 16'd1;
    end
  end

  assign eps_valid = eps_valid_r;
  assign eps       = eps_r;
  assign eps_err   = eps_err_r;
  assign peak_drop = peak_drop_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_select_eps.sv
// Self-checking bench for select_eps: directed scenarios plus randomized peaks,
// checked every cycle against a cycle-scheduled reference of expected pulses.
module tb_select_eps;

  localparam int W = 13;

  logic             clk = 1'b0;
  logic             rst;
  logic             buf_valid;
  logic [256*W-1:0] angle_buf;
  logic [7:0]       write_ptr;
  logic             peak_valid;
  logic [7:0]       peak_idx;
  logic             eps_valid;
  logic [W-1:0]     eps;
  logic             eps_err;
  logic             peak_drop;
  logic             busy;

  select_eps dut (
    .clk(clk), .rst(rst), .buf_valid(buf_valid), .angle_buf(angle_buf),
    .write_ptr(write_ptr), .peak_valid(peak_valid), .peak_idx(peak_idx),
    .eps_valid(eps_valid), .eps(eps), .eps_err(eps_err),
    .peak_drop(peak_drop), .busy(busy)
  );

  always #5 clk = ~clk;

  int ncomp = 0;
  int nfail = 0;
  int cyc = 0;
  int mbuf[256];
  int wp_m = 0;
  int sum_m = 0;
  int cnt_m = 0;
  int busy_until = -1;
  int eps_m = 0;
  int last_peak = 0;
  bit exp_v[int];
  bit exp_err[int];
  bit exp_drop[int];
  int exp_eps_at[int];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int floor_div4(input int n);
    int q;
    q = n / 4;
    if ((n % 4 != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (exp_eps_at.exists(cyc)) eps_m = exp_eps_at[cyc];
    check("eps_valid", eps_valid, exp_v.exists(cyc));
    check("eps_err", eps_err, exp_err.exists(cyc));
    check("peak_drop", peak_drop, exp_drop.exists(cyc));
    check("busy", busy, (cyc <= busy_until) ? 1 : 0);
    check("eps", $signed(eps), eps_m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_buf(input int i, input int v);
    angle_buf[i*W +: W] = W'(v);
    mbuf[i] = v;
  endtask

  task automatic set_wp(input int p);
    write_ptr = 8'(p);
    wp_m = p;
  endtask

  // A peak whose sample is taken at cycle c: mean ready three cycles later.
  task automatic accept(input int c, input int sample);
    sum_m += sample;
    cnt_m++;
    if (cnt_m == 4) begin
      exp_v[c+3] = 1'b1;
      exp_eps_at[c+3] = floor_div4(sum_m + 2);
      busy_until = c + 3;
      sum_m = 0;
      cnt_m = 0;
    end else begin
      busy_until = c + 2;
    end
  endtask

  task automatic peak(input int idx);
    int c;
    int d;
    c = cyc;
    last_peak = c;
    peak_valid = 1'b1;
    peak_idx = 8'(idx);
    if (c <= busy_until) begin
      exp_drop[c+1] = 1'b1;
    end else begin
      d = (((wp_m - idx) % 256) + 256) % 256;
      if (d == 0) begin
        busy_until = c + 1024;
        exp_err[c+1025] = 1'b1;
      end else if (d > 192) begin
        exp_err[c+1] = 1'b1;
      end else begin
        accept(c, mbuf[idx]);
      end
    end
    tick();
    peak_valid = 1'b0;
  endtask

  int rv;
  int d;
  int idx;
  int pc;
  int accepted;

  initial begin
    rst = 1'b1;
    buf_valid = 1'b0;
    angle_buf = '0;
    write_ptr = 8'd0;
    peak_valid = 1'b0;
    peak_idx = 8'd0;
    for (int i = 0; i < 256; i++) mbuf[i] = 0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // 1: positive mean with fractional part
    set_wp(50);
    set_buf(10, 100); set_buf(20, 200); set_buf(30, 300); set_buf(40, 401);
    peak(10); idle(3); peak(20); idle(3); peak(30); idle(3); peak(40); idle(2);
    check("t1_eps_250", $signed(eps), 250);
    check("t1_eps_valid", eps_valid, 1);
    idle(3);

    // 2: negative mean, round half toward +inf
    set_buf(11, -3); set_buf(12, -3); set_buf(13, -2); set_buf(14, -2);
    peak(11); idle(3); peak(12); idle(3); peak(13); idle(3); peak(14); idle(2);
    check("t2_eps_bits", eps, 13'h1FFE);
    idle(3);

    // 3: peak on not-yet-written entry, resolved five cycles later
    set_wp(60);
    set_buf(60, 0);
    peak(60);
    pc = last_peak;
    idle(4);
    set_buf(60, 77);
    set_wp(61);
    buf_valid = 1'b1;
    exp_err.delete(pc + 1025);
    accept(pc + 5, 77);
    tick();
    buf_valid = 1'b0;
    idle(3);
    set_buf(45, 10); set_buf(46, -20); set_buf(47, 1);
    peak(45); idle(3); peak(46); idle(3); peak(47); idle(4);

    // 4: stale entry rejected, count unchanged
    set_wp(5);
    set_buf(10, 999);
    peak(10); idle(2);
    // Wrap-around: index 255 with pointer 0 is one entry old
    set_wp(0);
    set_buf(255, -4000); set_buf(250, -3000); set_buf(200, 4095);
    peak(255); idle(3); peak(250); idle(3);
    set_wp(5);
    peak(10); idle(2);
    set_wp(0);
    peak(200); idle(3); set_buf(128, 4095); peak(128); idle(4);

    // 5: WAIT timeout, then peak during READ is dropped
    set_wp(70);
    peak(70);
    idle(1030);
    set_buf(66, 123);
    peak(66); peak(66); idle(3);

    // 6: reset mid-average (peak coinciding with reset is ignored)
    set_buf(67, 3000); set_buf(68, 3000);
    peak(67); idle(3); peak(68); idle(3);
    rst = 1'b1;
    peak_valid = 1'b1;
    peak_idx = 8'd67;
    sum_m = 0;
    cnt_m = 0;
    busy_until = -1;
    eps_m = 0;
    tick();
    peak_valid = 1'b0;
    rst = 1'b0;
    idle(2);
    set_buf(60, -1); set_buf(61, -1); set_buf(62, -1); set_buf(63, 1);
    set_wp(64);
    peak(60); idle(3); peak(61); idle(3); peak(62); idle(3); peak(63); idle(2);
    check("t6_eps_after_rst", $signed(eps), 0);
    idle(3);

    // Randomized groups with occasional stale and dropped peaks
    for (int g = 0; g < 12; g++) begin
      set_wp(int'($urandom_range(0, 255)));
      accepted = 0;
      while (accepted < 4) begin
        if ($urandom_range(0, 5) == 0) d = int'($urandom_range(193, 255));
        else begin
          d = int'($urandom_range(1, 192));
          accepted++;
        end
        idx = (wp_m - d) & 255;
        rv = int'($urandom_range(0, 8191)) - 4096;
        set_buf(idx, rv);
        peak(idx);
        pc = last_peak;
        if ($urandom_range(0, 3) == 0) peak(int'($urandom_range(0, 255)));
        while (cyc < pc + 3) tick();
        idle(int'($urandom_range(0, 2)));
      end
      idle(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
